uart_time_reporter: RTL and testbench
=====================================

// Module: uart_time_reporter
// PURPOSE
//  Transmit-side formatter for the UART watch: on a report request it snapshots the current
//  watch/stopwatch time and streams an ASCII frame into the TX FIFO, e.g. "W 12:34:56.78\r\n".
//  Sits between the time counters and the TX FIFO push port, in the opposite direction to the
//  RX command decoder. The decoder pulses req, e.g. on '?'.
// PARAMETERS
//  PREFIX_W   8'h57 ("W")  prefix character when mode=0 (watch)
//  PREFIX_S   8'h53 ("S")  prefix character when mode=1 (stopwatch)
//  EOL_CRLF   1            1: frame ends CR,LF (15 bytes); 0: frame ends LF only (14 bytes)
// PORTS
//  clk         in   1  system clock, 100 MHz
//  rst         in   1  asynchronous reset, active-high
//  req         in   1  report request; sampled only in IDLE, ignored otherwise
//  mode        in   1  0=watch, 1=stopwatch; selects the prefix; snapshotted with the time
//  hour        in   5  hours, 0..31 (binary)
//  min         in   6  minutes, 0..63 (binary)
//  sec         in   6  seconds, 0..63 (binary)
//  csec        in   7  centiseconds, 0..127 (binary)
//  fifo_full   in   1  TX FIFO full; no push is issued in a cycle where it is 1
//  fifo_push   out  1  one-cycle push strobe per byte
//  fifo_wdata  out  8  byte pushed; valid whenever fifo_push=1
//  busy        out  1  high in SEND and DONE
//  done        out  1  one-cycle pulse after the last byte is pushed
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, fifo_push=0, fifo_wdata=0, busy=0, done=0, snapshot regs=0.
//  FSM IDLE -> SEND: on a clk edge with req=1. At that edge mode/hour/min/sec/csec are latched,
//    so later input changes do not affect the frame.
//  SEND:
//    - fifo_push = (state==SEND) & ~fifo_full, combinational.
//    - fifo_wdata = frame[idx].
//    - idx increments on every push.
//    - After the push of the last byte the FSM goes to DONE.
//  DONE: done=1 for exactly one cycle, then IDLE. A req seen in SEND or DONE is dropped, not queued.
//  Frame byte order:
//    prefix, ' ', H1, H0, ':', M1, M0, ':', S1, S0, '.', C1, C0, [CR 8'h0D], LF 8'h0A.
//  Digit conversion:
//    - X1 = v/10, X0 = v%10, each emitted as 8'h30 + digit.
//    - Values above 99 (csec only) saturate to "99". Otherwise there is no range check, e.g. min=63 gives "63".
//  Latency, FIFO never full:
//    - req sampled at edge N; bytes pushed in cycles N+1 .. N+15 (CRLF).
//    - done=1 in cycle N+16; IDLE at N+17; next req can be sampled at the N+17 edge.
//  Backpressure: fifo_full=1 stalls with idx held and no push; the byte is not skipped or repeated.
//    A stall of any length is legal.
//  Simultaneous events: fifo_full rising in the same cycle as the last byte blocks that push.
//    DONE is entered only after the last byte is actually pushed.
//  Reset mid-frame: returns to IDLE on the next cycle with no further pushes.
//    Bytes already pushed stay in the FIFO; no recovery frame is sent.
// TESTING
//  1 Basic: mode=0, 12:34:56.78, req pulse, fifo_full=0 -> 15 pushes
//    "W 12:34:56.78\r\n" on consecutive cycles N+1..N+15; done at N+16.
//  2 Stopwatch/zero: mode=1, all time inputs 0 -> "S 00:00:00.00\r\n"; csec=120 -> C1C0 = "99".
//  3 Backpressure: fifo_full high for 7 cycles around byte 5 (':') -> byte stream identical to
//    the unstalled case; no push while full; done delayed by 7 cycles.
//  4 Snapshot: change sec 45 -> 46 one cycle after req -> frame still carries "45".
//  5 Request while busy: second req at N+5 -> ignored; exactly 15 pushes.
//    A req at N+17 -> second full frame.
//  6 Reset mid-frame: assert rst after byte 6 -> fifo_push=0 at once, busy=0.
//    A new req then yields a complete frame from the prefix byte.
//  Each scenario is rerun with EOL_CRLF=0 -> 14 bytes, no 8'h0D; done at N+15.

Source files
------------

// File: rtl/uart_time_reporter.sv
// Formats a snapshot of the watch/stopwatch time as "P HH:MM:SS.CC" plus CR,LF or LF
// and pushes it into the TX FIFO one byte per cycle, holding position while the FIFO is full.
module uart_time_reporter #(
  parameter logic [7:0] PREFIX_W = 8'h57,
  parameter logic [7:0] PREFIX_S = 8'h53,
  parameter bit         EOL_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       mode,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] csec,
  input  logic       fifo_full,
  output logic       fifo_push,
  output logic [7:0] fifo_wdata,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = EOL_CRLF ? 4'd14 : 4'd13;

  state_t     state;
  logic [3:0] idx;
  logic       snap_mode;
  logic [4:0] snap_hour;
  logic [5:0] snap_min;
  logic [5:0] snap_sec;
  logic [6:0] snap_csec;
  logic [7:0] frame_byte;

  logic [15:0] hour_txt;
  logic [15:0] min_txt;
  logic [15:0] sec_txt;
  logic [15:0] csec_txt;

  // Two ASCII digits {tens, ones}; anything above 99 reads as "99".
  function automatic logic [15:0] two_digits(input logic [6:0] v);
    logic [6:0] s;
    logic [6:0] tens;
    logic [6:0] ones;
    s    = (v > 7'd99) ? 7'd99 : v;
    tens = s / 7'd10;
    ones = s % 7'd10;
    return {8'h30 + {1'b0, tens}, 8'h30 + {1'b0, ones}};
  endfunction

  assign hour_txt = two_digits({2'b00, snap_hour});
  assign min_txt  = two_digits({1'b0, snap_min});
  assign sec_txt  = two_digits({1'b0, snap_sec});
  assign csec_txt = two_digits(snap_csec);

  always_comb begin
    frame_byte = 8'h00;
    case (idx)
      4'd0:    frame_byte = snap_mode ? PREFIX_S : PREFIX_W;
      4'd1:    frame_byte = 8'h20;
      4'd2:    frame_byte = hour_txt[15:8];
      4'd3:    frame_byte = hour_txt[7:0];
      4'd4:    frame_byte = 8'h3A;
      4'd5:    frame_byte = min_txt[15:8];
      4'd6:    frame_byte = min_txt[7:0];
      4'd7:    frame_byte = 8'h3A;
      4'd8:    frame_byte = sec_txt[15:8];
      4'd9:    frame_byte = sec_txt[7:0];
      4'd10:   frame_byte = 8'h2E;
      4'd11:   frame_byte = csec_txt[15:8];
      4'd12:   frame_byte = csec_txt[7:0];
      4'd13:   frame_byte = EOL_CRLF ? 8'h0D : 8'h0A;
      4'd14:   frame_byte = 8'h0A;
      default: frame_byte = 8'h00;
    endcase
  end

  // Push is gated by fifo_full in the same cycle so a stall never drops or repeats a byte.
  assign fifo_push  = (state == SEND) && !fifo_full;
  assign fifo_wdata = (state == SEND) ? frame_byte : 8'h00;
  assign busy       = (state == SEND) || (state == DONE);
  assign done       = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 4'd0;
      snap_mode <= 1'b0;
      snap_hour <= 5'd0;
      snap_min  <= 6'd0;
      snap_sec  <= 6'd0;
      snap_csec <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          idx <= 4'd0;
          if (req) begin
            snap_mode <= mode;
            snap_hour <= hour;
            snap_min  <= min;
            snap_sec  <= sec;
            snap_csec <= csec;
            state     <= SEND;
          end
        end
        SEND: begin
          if (fifo_push) begin
            if (idx == LAST_IDX) begin
              idx   <= 4'd0;
              state <= DONE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          idx   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_time_reporter.sv
// Bench for uart_time_reporter: a CR,LF instance and an LF-only instance share all inputs,
// each with its own expected-byte queue, latency model and done/busy checks.
module tb_uart_time_reporter;

  logic       clk;
  logic       rst;
  logic       req;
  logic       mode;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [6:0] csec;
  logic       fifo_full;

  logic       push_a, push_b;
  logic [7:0] wdata_a, wdata_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  int n_cmp;
  int n_err;
  int cyc;
  int done_cyc_a, done_cyc_b;
  int done_cnt_a, done_cnt_b;
  logic prev_done_a, prev_done_b;

  uart_time_reporter #(.EOL_CRLF(1'b1)) u_dut_crlf (
    .clk(clk), .rst(rst), .req(req), .mode(mode), .hour(hour), .min(min), .sec(sec),
    .csec(csec), .fifo_full(fifo_full), .fifo_push(push_a), .fifo_wdata(wdata_a),
    .busy(busy_a), .done(done_a)
  );

  uart_time_reporter #(.EOL_CRLF(1'b0)) u_dut_lf (
    .clk(clk), .rst(rst), .req(req), .mode(mode), .hour(hour), .min(min), .sec(sec),
    .csec(csec), .fifo_full(fifo_full), .fifo_push(push_b), .fifo_wdata(wdata_b),
    .busy(busy_b), .done(done_b)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (push_a) begin
        check("no_push_while_full_a", 32'(fifo_full), 32'd0);
        if (exp_a.size() == 0) check("extra_push_a", 32'(wdata_a), 32'hFFFF_FFFF);
        else check("byte_a", 32'(wdata_a), 32'(exp_a.pop_front()));
      end
      if (prev_done_a) check("done_one_cycle_a", 32'(done_a), 32'd0);
      if (done_a) begin
        check("busy_in_done_a", 32'(busy_a), 32'd1);
        done_cyc_a = cyc;
        done_cnt_a++;
      end
      prev_done_a = done_a;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (push_b) begin
        check("no_push_while_full_b", 32'(fifo_full), 32'd0);
        if (exp_b.size() == 0) check("extra_push_b", 32'(wdata_b), 32'hFFFF_FFFF);
        else check("byte_b", 32'(wdata_b), 32'(exp_b.pop_front()));
      end
      if (prev_done_b) check("done_one_cycle_b", 32'(done_b), 32'd0);
      if (done_b) begin
        check("busy_in_done_b", 32'(busy_b), 32'd1);
        done_cyc_b = cyc;
        done_cnt_b++;
      end
      prev_done_b = done_b;
    end
  end

  function automatic logic [7:0] dig(input int v);
    return 8'(48 + v);
  endfunction

  task automatic push_exp(input logic m, input int h, input int mi, input int s, input int c);
    logic [7:0] f[13];
    int cs;
    cs = (c > 99) ? 99 : c;
    f[0]  = m ? 8'h53 : 8'h57;
    f[1]  = 8'h20;
    f[2]  = dig(h / 10);  f[3]  = dig(h % 10);  f[4]  = 8'h3A;
    f[5]  = dig(mi / 10); f[6]  = dig(mi % 10); f[7]  = 8'h3A;
    f[8]  = dig(s / 10);  f[9]  = dig(s % 10);  f[10] = 8'h2E;
    f[11] = dig(cs / 10); f[12] = dig(cs % 10);
    for (int i = 0; i < 13; i++) begin
      exp_a.push_back(f[i]);
      exp_b.push_back(f[i]);
    end
    exp_a.push_back(8'h0D);
    exp_a.push_back(8'h0A);
    exp_b.push_back(8'h0A);
  endtask

  // Cycle (1-based after the req edge) of the last push, given a stall window.
  function automatic int last_push_cycle(input int len, input int ss, input int sl);
    int k;
    int pushed;
    k = 0;
    pushed = 0;
    while (pushed < len) begin
      k++;
      if (!(k >= ss && k < ss + sl)) pushed++;
    end
    return k;
  endfunction

  task automatic drive_time(input logic m, input int h, input int mi, input int s, input int c);
    mode = m;
    hour = 5'(h);
    min  = 6'(mi);
    sec  = 6'(s);
    csec = 7'(c);
  endtask

  // Drive one report: req sampled at the next edge, optional stall and stray request.
  task automatic run_frame(input logic m, input int h, input int mi, input int s, input int c,
                           input int stall_j, input int stall_len, input bit busy_req);
    int n;
    int ca0, cb0;
    bit timed_out;
    @(posedge clk);
    #2;
    drive_time(m, h, mi, s, c);
    push_exp(m, h, mi, s, c);
    ca0 = done_cnt_a;
    cb0 = done_cnt_b;
    req = 1'b1;
    @(posedge clk);
    #2;
    req = 1'b0;
    n = cyc;
    drive_time(~m, $urandom_range(0, 31), $urandom_range(0, 63), (s + 1) % 64,
               $urandom_range(0, 127));
    check("busy_after_req_a", 32'(busy_a), 32'd1);
    check("busy_after_req_b", 32'(busy_b), 32'd1);
    timed_out = 1'b1;
    fork
      begin
        if (stall_len > 0) begin
          repeat (stall_j) begin @(posedge clk); #2; end
          fifo_full = 1'b1;
          repeat (stall_len) begin @(posedge clk); #2; end
          fifo_full = 1'b0;
        end
      end
      begin
        if (busy_req) begin
          repeat (4) begin @(posedge clk); #2; end
          req = 1'b1;
          @(posedge clk);
          #2;
          req = 1'b0;
        end
      end
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          #1;
          if (done_cnt_a > ca0 && done_cnt_b > cb0) begin
            timed_out = 1'b0;
            break;
          end
        end
      end
    join
    check("done_timeout", 32'(timed_out), 32'd0);
    check("frame_complete_a", 32'(exp_a.size()), 32'd0);
    check("frame_complete_b", 32'(exp_b.size()), 32'd0);
    check("latency_a", 32'(done_cyc_a - n), 32'(last_push_cycle(15, stall_j + 1, stall_len)));
    check("latency_b", 32'(done_cyc_b - n), 32'(last_push_cycle(14, stall_j + 1, stall_len)));
  endtask

  task automatic reset_mid_frame();
    @(posedge clk);
    #2;
    drive_time(1'b0, 9, 8, 7, 6);
    push_exp(1'b0, 9, 8, 7, 6);
    req = 1'b1;
    @(posedge clk);
    #2;
    req = 1'b0;
    repeat (6) begin @(posedge clk); #2; end
    check("bytes_before_reset_a", 32'(exp_a.size()), 32'd9);
    check("bytes_before_reset_b", 32'(exp_b.size()), 32'd8);
    rst = 1'b1;
    #1;
    check("push_at_reset_a", 32'(push_a), 32'd0);
    check("push_at_reset_b", 32'(push_b), 32'd0);
    check("busy_at_reset_a", 32'(busy_a), 32'd0);
    check("busy_at_reset_b", 32'(busy_b), 32'd0);
    exp_a.delete();
    exp_b.delete();
    prev_done_a = 1'b0;
    prev_done_b = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset_a", 32'({push_a, busy_a}), 32'd0);
    check("idle_after_reset_b", 32'({push_b, busy_b}), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    done_cnt_a = 0;
    done_cnt_b = 0;
    done_cyc_a = 0;
    done_cyc_b = 0;
    prev_done_a = 1'b0;
    prev_done_b = 1'b0;
    rst = 1'b1;
    req = 1'b0;
    fifo_full = 1'b0;
    drive_time(1'b0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_a", 32'({push_a, wdata_a, busy_a, done_a}), 32'd0);
    check("reset_outputs_b", 32'({push_b, wdata_b, busy_b, done_b}), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    run_frame(1'b0, 12, 34, 56, 78, 0, 0, 1'b0);
    run_frame(1'b1, 0, 0, 0, 0, 0, 0, 1'b0);
    run_frame(1'b0, 23, 59, 59, 120, 0, 0, 1'b0);
    run_frame(1'b1, 31, 63, 63, 127, 0, 0, 1'b0);
    run_frame(1'b0, 12, 34, 56, 78, 4, 7, 1'b0);
    run_frame(1'b1, 5, 6, 7, 99, 14, 3, 1'b0);
    run_frame(1'b0, 1, 2, 45, 3, 0, 0, 1'b0);
    run_frame(1'b0, 10, 20, 30, 40, 0, 0, 1'b1);
    run_frame(1'b1, 11, 22, 33, 44, 0, 0, 1'b0);
    reset_mid_frame();
    run_frame(1'b0, 8, 9, 10, 11, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 63),
                $urandom_range(0, 63), $urandom_range(0, 127), $urandom_range(0, 14),
                $urandom_range(0, 5), 1'b0);
    end
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
